// File: rtl/game_countdown_timer.sv
// game_countdown_timer: seconds countdown for game rounds.
// Prescaled 1 Hz tick, pause/resume, saturating bonus time, reload mode.
module game_countdown_timer #(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int COUNT_W       = 8,
  parameter int AUTO_RELOAD   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] loadValue,
  input  logic               enable,
  input  logic               addTime,
  input  logic [COUNT_W-1:0] addValue,
  output logic               secPulse,
  output logic [COUNT_W-1:0] remaining,
  output logic               running,
  output logic               expired,
  output logic               done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [PW-1:0]      presc, presc_n;
  logic [COUNT_W-1:0] rem_q, rem_n;
  logic [COUNT_W-1:0] rld_q, rld_n;
  logic               sec_q, sec_n;
  logic               exp_q, exp_n;
  logic               active, tick, add_ok;
  logic [COUNT_W+1:0] sum;
  logic [COUNT_W-1:0] sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      rem_q <= '0;
      rld_q <= '0;
      sec_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      rem_q <= rem_n;
      rld_q <= rld_n;
      sec_q <= sec_n;
      exp_q <= exp_n;
    end
  end

  // Two guard bits: one for add overflow, one for tick underflow.
  always_comb begin
    active = (state == RUN) || (state == PAUSE);
    tick   = active && enable && (presc == PS_LAST);
    add_ok = active && addTime;
    sum    = {2'b00, rem_q}
           + (add_ok ? {2'b00, addValue} : '0)
           - (COUNT_W+2)'(tick);
    if (sum[COUNT_W+1]) begin
      sat = '0;
    end else if (sum[COUNT_W]) begin
      sat = CNT_MAX;
    end else begin
      sat = sum[COUNT_W-1:0];
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    rem_n   = rem_q;
    rld_n   = rld_q;
    sec_n   = 1'b0;
    exp_n   = 1'b0;
    if (load) begin
      rem_n   = loadValue;
      rld_n   = loadValue;
      presc_n = '0;
      if (loadValue == '0) begin
        state_n = DONE;
        exp_n   = 1'b1;
      end else begin
        state_n = enable ? RUN : PAUSE;
      end
    end else if (active) begin
      state_n = enable ? RUN : PAUSE;
      if (enable) begin
        presc_n = tick ? '0 : presc + 1'b1;
      end
      rem_n = sat;
      sec_n = tick;
      // Expiry only on a tick whose combined result is zero.
      if (tick && (sat == '0)) begin
        exp_n = 1'b1;
        if (AUTO_RELOAD != 0) begin
          rem_n = rld_q;
        end else begin
          state_n = DONE;
          presc_n = '0;
        end
      end
    end
  end

  assign secPulse  = sec_q;
  assign remaining = rem_q;
  assign expired   = exp_q;
  assign running   = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: scenario tasks plus random traffic
// against a cycle-budget reference model, both expiry modes.
module tb_game_countdown_timer;

  localparam int T = 4;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset, load, enable, addTime;
  logic [W-1:0] loadValue, addValue;
  logic sp0, ex0, dn0, rn0, sp1, ex1, dn1, rn1;
  logic [W-1:0] rm0, rm1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  game_countdown_timer #(
    .TICKS_PER_SEC(T), .COUNT_W(W), .AUTO_RELOAD(0)
  ) dut0 (
    .clk(clk), .reset(reset), .load(load),
    .loadValue(loadValue), .enable(enable),
    .addTime(addTime), .addValue(addValue),
    .secPulse(sp0), .remaining(rm0), .running(rn0),
    .expired(ex0), .done(dn0)
  );

  game_countdown_timer #(
    .TICKS_PER_SEC(T), .COUNT_W(W), .AUTO_RELOAD(1)
  ) dut1 (
    .clk(clk), .reset(reset), .load(load),
    .loadValue(loadValue), .enable(enable),
    .addTime(addTime), .addValue(addValue),
    .secPulse(sp1), .remaining(rm1), .running(rn1),
    .expired(ex1), .done(dn1)
  );

  // Model: count enabled cycles left until the next second.
  typedef struct packed {
    bit sp; bit ex; bit dn; bit rn; bit cnt;
    int rem; int rld; int bud;
  } mdl_t;

  mdl_t mdl[2];

  function automatic mdl_t mstep(mdl_t s, bit ar);
    mdl_t n;
    int v;
    bit tk;
    n = s;
    n.sp = 0;
    n.ex = 0;
    if (reset) begin
      n = '0;
      n.bud = T;
    end else if (load) begin
      n.rem = int'(loadValue);
      n.rld = int'(loadValue);
      n.bud = T;
      if (loadValue == 0) begin
        n.dn = 1; n.ex = 1; n.cnt = 0; n.rn = 0;
      end else begin
        n.dn = 0; n.cnt = 1; n.rn = enable;
      end
    end else if (s.cnt) begin
      n.rn = enable;
      tk = 0;
      if (enable) begin
        n.bud = s.bud - 1;
        if (n.bud == 0) begin
          tk = 1;
          n.bud = T;
        end
      end
      v = s.rem + (addTime ? int'(addValue) : 0) - int'(tk);
      if (v > MAXV) v = MAXV;
      if (v < 0) v = 0;
      n.rem = v;
      n.sp = tk;
      if (tk && v == 0) begin
        n.ex = 1;
        if (ar) begin
          n.rem = s.rld;
        end else begin
          n.cnt = 0; n.dn = 1; n.rn = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mdl[0] <= mstep(mdl[0], 1'b0);
    mdl[1] <= mstep(mdl[1], 1'b1);
  end

  logic [W+3:0] obs0, obs1, exp0, exp1;
  assign obs0 = {sp0, ex0, dn0, rn0, rm0};
  assign obs1 = {sp1, ex1, dn1, rn1, rm1};
  assign exp0 = {mdl[0].sp, mdl[0].ex, mdl[0].dn,
                 mdl[0].rn, W'(mdl[0].rem)};
  assign exp1 = {mdl[1].sp, mdl[1].ex, mdl[1].dn,
                 mdl[1].rn, W'(mdl[1].rem)};

  task automatic set_in(input bit l, input int lv,
                        input bit en, input bit at,
                        input int av);
    load      = l;
    loadValue = W'(lv);
    enable    = en;
    addTime   = at;
    addValue  = W'(av);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({obs0, obs1} !== '0) begin
        fails++;
        $display("FAIL reset c%0d got %h/%h want 0",
                 c, obs0, obs1);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    logic [W+3:0] want;
    int r;
    set_in(1, 3, 1, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      set_in(0, 0, 1, 0, 0);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL countdown_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      r = (c < 5) ? 3 : (c < 9) ? 2 : (c < 13) ? 1 : 0;
      want = {(c == 5 || c == 9 || c == 13), (c == 13),
              (c >= 13), (c < 13), W'(r)};
      checks++;
      if (obs0 !== want) begin
        fails++;
        $display("FAIL countdown c%0d got %h want %h",
                 c, obs0, want);
      end
    end
  endtask

  task automatic test_pause();
    bit en;
    set_in(1, 2, 1, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      en = !(c >= 3 && c <= 8);
      set_in(0, 0, en, 0, 0);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL pause_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      checks++;
      if ({sp0, rn0, rm0} !==
          {(c == 11), (c <= 3 || c >= 10), W'(c < 11 ? 2 : 1)}) begin
        fails++;
        $display("FAIL pause c%0d got sp=%b rn=%b rem=%0d",
                 c, sp0, rn0, rm0);
      end
    end
  endtask

  task automatic test_add_tick();
    set_in(1, 1, 1, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      set_in(0, 0, 1, (c == 4), 5);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL addtick_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      if (c == 5) begin
        checks++;
        if ({sp0, ex0, dn0, rn0, rm0, ex1, rm1} !==
            {4'b1001, W'(5), 1'b0, W'(5)}) begin
          fails++;
          $display("FAIL addtick got %h/%h want rem 5 no expiry",
                   obs0, obs1);
        end
      end
    end
    set_in(1, 250, 1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      set_in(0, 0, 1, (c == 1), 10);
      if (c == 2) begin
        checks++;
        if ({rm0, rm1} !== {W'(MAXV), W'(MAXV)}) begin
          fails++;
          $display("FAIL saturate got %0d/%0d want %0d",
                   rm0, rm1, MAXV);
        end
      end
    end
  endtask

  task automatic test_load_priority();
    set_in(1, 9, 1, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) set_in(1, 7, 1, 1, 3);
      else set_in(0, 0, 1, 0, 0);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL loadprio_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      if (c >= 4) begin
        checks++;
        if ({sp0, rm0} !== {(c == 8), W'(c < 8 ? 7 : 6)}) begin
          fails++;
          $display("FAIL loadprio c%0d got sp=%b rem=%0d",
                   c, sp0, rm0);
        end
      end
    end
    set_in(1, 0, 1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      set_in(0, 0, 1, (c == 2), 9);
      checks++;
      if ({sp0, ex0, dn0, rm0, sp1, ex1, dn1, rm1} !==
          {1'b0, (c == 1), 1'b1, W'(0),
           1'b0, (c == 1), 1'b1, W'(0)}) begin
        fails++;
        $display("FAIL zeroload c%0d got %h/%h", c, obs0, obs1);
      end
    end
  endtask

  task automatic test_auto_reload();
    set_in(1, 2, 1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      set_in(0, 0, 1, 0, 0);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL reload_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      checks++;
      if ({ex1, dn1, rn1, rm1} !==
          {(c == 9 || c == 17), 2'b01,
           W'((((c - 1) / 4) % 2 == 0) ? 2 : 1)}) begin
        fails++;
        $display("FAIL reload c%0d got ex=%b dn=%b rem=%0d",
                 c, ex1, dn1, rm1);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 3, 1, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      reset = (c == 6);
      if (c == 6) set_in(1, 5, 1, 0, 0);
      else set_in(0, 0, 1, (c % 3 == 0), 4);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL midreset_model c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      if (c >= 7) begin
        checks++;
        if ({obs0, obs1} !== '0) begin
          fails++;
          $display("FAIL midreset c%0d got %h/%h want 0",
                   c, obs0, obs1);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    int lv, av, k;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({obs0, obs1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL random c%0d got %h/%h want %h/%h",
                 c, obs0, obs1, exp0, exp1);
      end
      k = $urandom_range(0, 9);
      lv = (k == 0) ? 0 : (k == 1) ? $urandom_range(240, MAXV)
                                   : $urandom_range(1, 5);
      av = ($urandom_range(0, 4) == 0) ? $urandom_range(200, MAXV)
                                       : $urandom_range(0, 6);
      reset = ($urandom_range(0, 499) == 0);
      set_in(($urandom_range(0, 39) == 0), lv,
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 14) == 0), av);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 1, 0, 0);
    test_reset();
    test_countdown();
    test_pause();
    test_add_tick();
    test_load_priority();
    test_auto_reload();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
